pooling_output_buffer: RTL and testbench

- Parametrised, double-buffered collector between the pooling layer and the next layer.
- Takes IN_SIZE pooled words per beat, tagged with a feature index, and assembles one OUT_SIZE-word row per feature for all TOTAL_FEATURE features.
- Drains each completed frame as TOTAL_FEATURE row beats over a valid/ready stream.
- Ping-pong banks let frame N+1 fill while frame N drains.

---
 rtl/pooling_output_buffer_if.sv | 29 ++
 rtl/pooling_output_buffer.sv | 138 +++++++++++++
 tb/tb_pooling_output_buffer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pooling_output_buffer_if.sv
// Stream bundle between the pooling layer, the output buffer and the next layer.
// The master is the environment that feeds beats in and consumes rows; the slave is the buffer.
interface pooling_output_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_SIZE    = 6,
    parameter int OUT_SIZE   = 12,
    parameter int FEAT_W     = 3
);
    logic                           in_valid;
    logic                           in_ready;
    logic [FEAT_W-1:0]              feature_idx;
    logic [IN_SIZE*DATA_WIDTH-1:0]  data_in;
    logic                           out_valid;
    logic                           out_ready;
    logic [FEAT_W-1:0]              out_feature_idx;
    logic [OUT_SIZE*DATA_WIDTH-1:0] data_out;
    logic                           frame_done;
    logic                           err;

    modport master (
        output in_valid, feature_idx, data_in, out_ready,
        input  in_ready, out_valid, out_feature_idx, data_out, frame_done, err
    );

    modport slave (
        input  in_valid, feature_idx, data_in, out_ready,
        output in_ready, out_valid, out_feature_idx, data_out, frame_done, err
    );
endinterface

// File: rtl/pooling_output_buffer.sv
// Ping-pong row assembler: one bank collects IN_SIZE-word chunks per feature while
// the other drains finished OUT_SIZE-word rows, one per cycle, over valid/ready.
module pooling_output_buffer #(
    parameter int DATA_WIDTH    = 16,
    parameter int IN_SIZE       = 6,
    parameter int OUT_SIZE      = 12,
    parameter int TOTAL_FEATURE = 6,
    parameter int FEAT_W        = 3
) (
    input logic                   clk,
    input logic                   rst_n,
    pooling_output_buffer_if.slave bus
);
    localparam int CHUNKS      = OUT_SIZE / IN_SIZE;
    localparam int CNT_W       = $clog2(CHUNKS + 1);
    localparam int CHUNK_IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int BEAT_W      = IN_SIZE * DATA_WIDTH;
    localparam int ROW_W       = OUT_SIZE * DATA_WIDTH;

    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(CHUNKS);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [FEAT_W:0]   FEAT_LIMIT = (FEAT_W + 1)'(TOTAL_FEATURE);
    localparam logic [FEAT_W-1:0] LAST_FEAT  = FEAT_W'(TOTAL_FEATURE - 1);
    localparam logic [FEAT_W-1:0] FEAT_ONE   = FEAT_W'(1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

    bank_state_e       state_q [2];
    logic              fill_bank_q;
    logic              drain_bank_q;
    logic [CNT_W-1:0]  cnt_q [TOTAL_FEATURE];
    logic              out_valid_q;
    logic [FEAT_W-1:0] out_idx_q;
    logic [ROW_W-1:0]  data_out_q;
    logic              frame_done_q;
    logic              err_q;
    logic [BEAT_W-1:0] mem [2][TOTAL_FEATURE][CHUNKS];

    logic              accept;
    logic              feat_ok;
    logic              beat_ok;
    logic              bank_done;
    logic [CNT_W-1:0]  cur_cnt;
    logic              drain_step;
    logic              last_row;
    logic              rd_bank;
    logic [FEAT_W-1:0] rd_idx;
    logic [ROW_W-1:0]  rd_row;

    // Input is blocked only while the bank next in line to fill still holds a frame.
    assign bus.in_ready        = (state_q[fill_bank_q] == EMPTY) || (state_q[fill_bank_q] == FILLING);
    assign bus.out_valid       = out_valid_q;
    assign bus.out_feature_idx = out_idx_q;
    assign bus.data_out        = data_out_q;
    assign bus.frame_done      = frame_done_q;
    assign bus.err             = err_q;

    always_comb begin
        accept    = bus.in_valid && bus.in_ready;
        feat_ok   = {1'b0, bus.feature_idx} < FEAT_LIMIT;
        cur_cnt   = feat_ok ? cnt_q[bus.feature_idx] : CNT_FULL;
        beat_ok   = accept && (cur_cnt != CNT_FULL);
        bank_done = beat_ok;
        for (int f = 0; f < TOTAL_FEATURE; f++) begin
            if (FEAT_W'(f) == bus.feature_idx) bank_done &= ((cur_cnt + CNT_ONE) == CNT_FULL);
            else                               bank_done &= (cnt_q[f] == CNT_FULL);
        end
    end

    // Row to load into data_out on the next edge: the following row, the other bank's first row, or row 0.
    always_comb begin
        drain_step = out_valid_q && bus.out_ready;
        last_row   = (out_idx_q == LAST_FEAT);
        rd_bank    = drain_bank_q;
        rd_idx     = '0;
        if (drain_step && !last_row) rd_idx  = out_idx_q + FEAT_ONE;
        else if (drain_step)         rd_bank = ~drain_bank_q;
        for (int c = 0; c < CHUNKS; c++) rd_row[c*BEAT_W +: BEAT_W] = mem[rd_bank][rd_idx][c];
    end

    // NOTE: bank storage has no reset; bank states and chunk counters decide what is valid.
    always_ff @(posedge clk) begin
        if (beat_ok) mem[fill_bank_q][bus.feature_idx][cur_cnt[CHUNK_IDX_W-1:0]] <= bus.data_in;
    end

    // NOTE: all sequential state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) state_q[b] <= EMPTY;
            for (int f = 0; f < TOTAL_FEATURE; f++) cnt_q[f] <= '0;
            fill_bank_q  <= 1'b0;
            drain_bank_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            data_out_q   <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (accept && !beat_ok) err_q <= 1'b1;

            if (beat_ok) begin
                if (bank_done) begin
                    state_q[fill_bank_q] <= FULL;
                    fill_bank_q          <= ~fill_bank_q;
                    for (int f = 0; f < TOTAL_FEATURE; f++) cnt_q[f] <= '0;
                end else begin
                    state_q[fill_bank_q]      <= FILLING;
                    cnt_q[bus.feature_idx]    <= cur_cnt + CNT_ONE;
                end
            end

            // The fill side only touches EMPTY/FILLING banks and the drain side only FULL/DRAINING ones.
            if (drain_step) begin
                if (last_row) begin
                    frame_done_q          <= 1'b1;
                    state_q[drain_bank_q] <= EMPTY;
                    drain_bank_q          <= ~drain_bank_q;
                    out_idx_q             <= '0;
                    if (state_q[~drain_bank_q] == FULL) begin
                        state_q[~drain_bank_q] <= DRAINING;
                        data_out_q             <= rd_row;
                    end else begin
                        out_valid_q <= 1'b0;
                    end
                end else begin
                    out_idx_q  <= rd_idx;
                    data_out_q <= rd_row;
                end
            end else if (!out_valid_q && state_q[drain_bank_q] == FULL) begin
                state_q[drain_bank_q] <= DRAINING;
                out_valid_q           <= 1'b1;
                out_idx_q             <= '0;
                data_out_q            <= rd_row;
            end
        end
    end
endmodule

// File: tb/tb_pooling_output_buffer.sv
// Directed bench: default 6x(2x6 words) instance plus a 3x(4x4 words) instance sharing clock and reset.
// Each pooled word encodes {frame, feature, chunk, word} so any misplaced word shows up in the rows.
module tb_pooling_output_buffer;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    pooling_output_buffer_if #(.DATA_WIDTH(16), .IN_SIZE(6), .OUT_SIZE(12), .FEAT_W(3)) i0 ();
    pooling_output_buffer_if #(.DATA_WIDTH(16), .IN_SIZE(4), .OUT_SIZE(16), .FEAT_W(2)) i1 ();

    pooling_output_buffer #(.DATA_WIDTH(16), .IN_SIZE(6), .OUT_SIZE(12), .TOTAL_FEATURE(6), .FEAT_W(3))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(i0));
    pooling_output_buffer #(.DATA_WIDTH(16), .IN_SIZE(4), .OUT_SIZE(16), .TOTAL_FEATURE(3), .FEAT_W(2))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [95:0] beat0(input int f, input int c, input int fr);
        logic [95:0] b;
        for (int w = 0; w < 6; w++) b[w*16 +: 16] = 16'((fr << 12) | (f << 8) | (c << 4) | w);
        return b;
    endfunction

    function automatic logic [63:0] beat1(input int f, input int c, input int fr);
        logic [63:0] b;
        for (int w = 0; w < 4; w++) b[w*16 +: 16] = 16'((fr << 12) | (f << 8) | (c << 4) | w);
        return b;
    endfunction

    function automatic logic [191:0] row0(input int f, input int fr);
        return {beat0(f, 1, fr), beat0(f, 0, fr)};
    endfunction

    function automatic logic [255:0] row1(input int f, input int fr);
        logic [255:0] r;
        for (int c = 0; c < 4; c++) r[c*64 +: 64] = beat1(f, c, fr);
        return r;
    endfunction

    task automatic send0(input int f, input logic [95:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        i0.in_valid    = 1'b1;
        i0.feature_idx = 3'(f);
        i0.data_in     = d;
        while (!i0.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("send0_in_ready_wait", 256'(guard < 200), 256'(1));
        @(posedge clk);
    endtask

    task automatic send1(input int f, input logic [63:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        i1.in_valid    = 1'b1;
        i1.feature_idx = 2'(f);
        i1.data_in     = d;
        while (!i1.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("send1_in_ready_wait", 256'(guard < 200), 256'(1));
        @(posedge clk);
    endtask

    task automatic send_frame0(input int fr);
        for (int f = 0; f < 6; f++)
            for (int c = 0; c < 2; c++) send0(f, beat0(f, c, fr));
    endtask

    task automatic idle0();
        @(negedge clk);
        i0.in_valid = 1'b0;
    endtask

    // Starts at a negedge where row 0 is expected; ends at the negedge showing frame_done.
    task automatic drain0(input int fr, input string tag);
        for (int r = 0; r < 6; r++) begin
            check({tag, "_valid"}, 256'(i0.out_valid), 256'(1));
            check({tag, "_idx"}, 256'(i0.out_feature_idx), 256'(r));
            check({tag, "_row"}, 256'(i0.data_out), 256'(row0(r, fr)));
            if (r > 0) check({tag, "_done_early"}, 256'(i0.frame_done), 256'(0));
            @(negedge clk);
        end
        check({tag, "_frame_done"}, 256'(i0.frame_done), 256'(1));
    endtask

    task automatic wait_valid0(input string tag);
        int guard;
        guard = 0;
        while (!i0.out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_wait_valid"}, 256'(guard < 50), 256'(1));
    endtask

    int ord_f [12] = '{3, 1, 3, 0, 5, 1, 2, 0, 4, 5, 2, 4};
    int ord_c [12] = '{0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 1, 1};

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        i0.in_valid = 1'b0; i0.feature_idx = '0; i0.data_in = '0; i0.out_ready = 1'b1;
        i1.in_valid = 1'b0; i1.feature_idx = '0; i1.data_in = '0; i1.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_in_ready", 256'(i0.in_ready), 256'(1));
        check("rst_out_valid", 256'(i0.out_valid), 256'(0));
        check("rst_out_idx", 256'(i0.out_feature_idx), 256'(0));
        check("rst_data_out", 256'(i0.data_out), 256'(0));
        check("rst_frame_done", 256'(i0.frame_done), 256'(0));
        check("rst_err", 256'(i0.err), 256'(0));
        check("rst1_in_ready", 256'(i1.in_ready), 256'(1));
        check("rst1_out_valid", 256'(i1.out_valid), 256'(0));

        // 1: in-order frame, two-cycle latency to the first row
        send_frame0(1);
        idle0();
        check("s1_latency_1cyc", 256'(i0.out_valid), 256'(0));
        @(negedge clk);
        drain0(1, "s1");
        check("s1_valid_after", 256'(i0.out_valid), 256'(0));
        @(negedge clk);
        check("s1_done_pulse_end", 256'(i0.frame_done), 256'(0));
        check("s1_err", 256'(i0.err), 256'(0));

        // 2: interleaved features
        for (int k = 0; k < 12; k++) send0(ord_f[k], beat0(ord_f[k], ord_c[k], 2));
        idle0();
        wait_valid0("s2");
        drain0(2, "s2");
        check("s2_err", 256'(i0.err), 256'(0));

        // 3: backpressure with both banks occupied, then back-to-back drain
        @(negedge clk);
        i0.out_ready = 1'b0;
        send_frame0(3);
        send_frame0(4);
        idle0();
        check("s3_in_ready_low", 256'(i0.in_ready), 256'(0));
        for (int k = 0; k < 20; k++) begin
            check("s3_hold_idx", 256'(i0.out_feature_idx), 256'(0));
            check("s3_hold_row", 256'(i0.data_out), 256'(row0(0, 3)));
            @(negedge clk);
        end
        check("s3_still_blocked", 256'(i0.in_ready), 256'(0));
        i0.out_ready = 1'b1;
        drain0(3, "s3a");
        check("s3_in_ready_back", 256'(i0.in_ready), 256'(1));
        drain0(4, "s3b");
        check("s3_valid_after", 256'(i0.out_valid), 256'(0));

        // 4: illegal feature index and chunk overflow
        send0(0, beat0(0, 0, 5));
        send0(1, beat0(1, 0, 5));
        idle0();
        check("s4_err_before", 256'(i0.err), 256'(0));
        send0(7, {6{16'hDEAD}});
        idle0();
        check("s4_err_bad_idx", 256'(i0.err), 256'(1));
        send0(2, beat0(2, 0, 5));
        send0(2, beat0(2, 1, 5));
        send0(2, {6{16'hBEEF}});
        for (int f = 0; f < 6; f++) begin
            if (f >= 3) send0(f, beat0(f, 0, 5));
            if (f != 2) send0(f, beat0(f, 1, 5));
        end
        idle0();
        wait_valid0("s4");
        drain0(5, "s4");
        check("s4_err_sticky", 256'(i0.err), 256'(1));

        // 5: reset mid-drain with a partly filled second bank
        @(negedge clk);
        i0.out_ready = 1'b0;
        send_frame0(6);
        for (int f = 0; f < 4; f++) send0(f, beat0(f, 0, 9));
        idle0();
        check("s5_row0_frame6", 256'(i0.data_out), 256'(row0(0, 6)));
        i0.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("s5_at_row3", 256'(i0.out_feature_idx), 256'(3));
        rst_n = 1'b0;
        #1;
        check("s5_rst_out_valid", 256'(i0.out_valid), 256'(0));
        check("s5_rst_in_ready", 256'(i0.in_ready), 256'(1));
        check("s5_rst_idx", 256'(i0.out_feature_idx), 256'(0));
        check("s5_rst_data", 256'(i0.data_out), 256'(0));
        check("s5_rst_err", 256'(i0.err), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        send_frame0(7);
        idle0();
        check("s5_latency_1cyc", 256'(i0.out_valid), 256'(0));
        @(negedge clk);
        drain0(7, "s5");

        // 6: narrow-beat, wide-row instance
        for (int f = 0; f < 3; f++)
            for (int c = 0; c < 4; c++) send1(f, beat1(f, c, 10));
        @(negedge clk);
        i1.in_valid = 1'b0;
        check("s6_latency_1cyc", 256'(i1.out_valid), 256'(0));
        @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            check("s6_valid", 256'(i1.out_valid), 256'(1));
            check("s6_idx", 256'(i1.out_feature_idx), 256'(r));
            check("s6_row", 256'(i1.data_out), row1(r, 10));
            @(negedge clk);
        end
        check("s6_frame_done", 256'(i1.frame_done), 256'(1));
        check("s6_valid_after", 256'(i1.out_valid), 256'(0));
        check("s6_err", 256'(i1.err), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
